// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and reset-default constants for the programmable serial
// pattern detector (seq_det_ctrl and seq_match_core).
//   state_t      : run-controller FSM state
//   DEF_*        : configuration loaded by reset (the classic 1001 detector,
//                  non-overlapping, unbounded window)
// -----------------------------------------------------------------------------
package seq_det_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [15:0] DEF_PATTERN = 16'b1001;
   localparam int unsigned DEF_LEN     = 4;
   localparam logic        DEF_OVERLAP = 1'b0;
   localparam int unsigned DEF_WINDOW  = 0;

endpackage

// File: rtl/seq_match_core.sv
// -----------------------------------------------------------------------------
// seq_match_core
// History shift register, fill counter and length-masked pattern compare.
//   clk, reset : clock, asynchronous active-high reset
//   shift_en   : accept data_in this cycle (shift history, advance fill)
//   clear      : zero the fill counter (start of a run)
//   data_in    : serial bit, enters history at bit 0
//   len        : active pattern length (1..MAX_LEN)
//   pattern    : pattern, bit [len-1] is the oldest bit
//   overlap    : 1 = keep fill after a hit, 0 = restart after a hit
//   hit        : combinational, the bit being accepted completes a match
// -----------------------------------------------------------------------------
module seq_match_core #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               shift_en,
   input  logic               clear,
   input  logic               data_in,
   input  logic [LEN_W-1:0]   len,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic               overlap,
   output logic               hit
);

   logic [MAX_LEN-1:0] hist_q;
   logic [MAX_LEN-1:0] hist_nxt;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W:0]     fill_inc;   // one extra bit so MAX_LEN+1 never wraps
   logic               enough;

   // NOTE: every signal written here gets a value before any condition, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      hist_nxt = {hist_q[MAX_LEN-2:0], data_in};
      fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);
      mask     = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LEN_W'(i) < len);
      end
      // The bit being accepted counts toward the fill, hence fill + 1.
      enough = (fill_inc >= {1'b0, len});
      hit    = shift_en && enough && ((hist_nxt & mask) == (pattern & mask));
   end

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   // NOTE: history is reset because it is only MAX_LEN flops; it is not cleared
   // at run start since the fill counter already masks out stale bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (clear) begin
         fill_q <= '0;
      end else if (shift_en) begin
         hist_q <= hist_nxt;
         if (hit && !overlap) begin
            fill_q <= '0;               // next match needs len fresh bits
         end else if (fill_inc > (LEN_W + 1)'(MAX_LEN)) begin
            fill_q <= LEN_W'(MAX_LEN);
         end else begin
            fill_q <= fill_inc[LEN_W-1:0];
         end
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Run controller for a programmable serial pattern detector. Holds the pattern
// configuration, sequences one detection run over a window of valid bits,
// counts matches and pulses done at the end of the window.
//   clk, reset   : clock, asynchronous active-high reset
//   cfg_wr       : config write strobe, honoured in IDLE only
//   cfg_pattern  : pattern, bit [len-1] is the first bit received
//   cfg_len      : pattern length, legal 1..MAX_LEN
//   cfg_overlap  : 1 = overlapping detection
//   cfg_window   : valid bits per run, 0 = unbounded
//   start        : begin a run (IDLE only)
//   abort        : end a run without done (RUN only)
//   data_valid   : qualifies data_in
//   data_in      : serial bit
//   busy         : high while in RUN
//   match        : registered one-cycle pulse per detection
//   match_count  : saturating match count of the current/last run
//   done         : one-cycle pulse after the last window bit
//   cfg_err      : sticky, an illegal cfg_len was written
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int WIN_W   = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             cfg_wr,
   input  logic [MAX_LEN-1:0]               cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len,
   input  logic                             cfg_overlap,
   input  logic [WIN_W-1:0]                 cfg_window,
   input  logic                             start,
   input  logic                             abort,
   input  logic                             data_valid,
   input  logic                             data_in,
   output logic                             busy,
   output logic                             match,
   output logic [CNT_W-1:0]                 match_count,
   output logic                             done,
   output logic                             cfg_err
);

   import seq_det_pkg::*;

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   state_t             state_q;
   state_t             state_nxt;

   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [WIN_W-1:0]   win_q;
   logic [WIN_W-1:0]   bit_cnt_q;

   logic               in_idle;
   logic               in_run;
   logic               len_legal;
   logic               cfg_load;
   logic               run_start;
   logic               accept;
   logic               last_bit;
   logic               hit;

   assign in_idle   = (state_q == S_IDLE);
   assign in_run    = (state_q == S_RUN);
   assign len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   assign cfg_load  = in_idle && cfg_wr && len_legal;
   assign run_start = in_idle && start;
   // Abort wins over data: a bit arriving with abort is discarded.
   assign accept    = in_run && data_valid && !abort;
   assign last_bit  = accept && (win_q != '0) && ((bit_cnt_q + WIN_W'(1)) == win_q);

   seq_match_core #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .shift_en (accept),
      .clear    (run_start),
      .data_in  (data_in),
      .len      (len_q),
      .pattern  (pat_q),
      .overlap  (ovl_q),
      .hit      (hit)
   );

   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN: begin
            if (abort)         state_nxt = S_IDLE;
            else if (last_bit) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Configuration: loads together with start so the new run sees it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q   <= MAX_LEN'(DEF_PATTERN);
         len_q   <= LEN_W'(DEF_LEN);
         ovl_q   <= DEF_OVERLAP;
         win_q   <= WIN_W'(DEF_WINDOW);
         cfg_err <= 1'b0;
      end else if (in_idle && cfg_wr) begin
         cfg_err <= !len_legal;
         if (cfg_load) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            win_q <= cfg_window;
         end
      end
   end

   // Window bit counter; only compared when the window is non-zero, so its
   // natural wrap in an unbounded run is harmless.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt_q <= '0;
      end else if (run_start) begin
         bit_cnt_q <= '0;
      end else if (accept) begin
         bit_cnt_q <= bit_cnt_q + WIN_W'(1);
      end
   end

   // Outputs: registered decodes of the next state and of the hit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         match       <= 1'b0;
         match_count <= '0;
      end else begin
         busy  <= (state_nxt == S_RUN);
         done  <= (state_nxt == S_DONE);
         match <= hit;
         if (run_start) begin
            match_count <= '0;
         end else if (hit && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
// Self-checking bench for seq_det_ctrl. A behavioural model keeps the accepted
// bits of the current run in a queue and decides matches by comparing the
// newest len bits against the pattern. Expected match/done events are queued
// by the driver and consumed by an independent monitor.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 2;
   localparam int WIN_W   = 8;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               cfg_wr = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic [WIN_W-1:0]   cfg_window = '0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic               data_valid = 1'b0;
   logic               data_in = 1'b0;
   logic               busy;
   logic               match;
   logic [CNT_W-1:0]   match_count;
   logic               done;
   logic               cfg_err;

   seq_det_ctrl #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W),
      .WIN_W   (WIN_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_wr      (cfg_wr),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_window  (cfg_window),
      .start       (start),
      .abort       (abort),
      .data_valid  (data_valid),
      .data_in     (data_in),
      .busy        (busy),
      .match       (match),
      .match_count (match_count),
      .done        (done),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit m;
      bit d;
      int cnt;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   // Reference model state
   int m_state = M_IDLE;
   int m_pat   = 9;
   int m_len   = 4;
   bit m_ovl   = 1'b0;
   int m_win   = 0;
   bit m_err   = 1'b0;
   int m_cnt   = 0;
   int m_nbits = 0;
   bit hist_bits[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE;
      m_pat   = 9;
      m_len   = 4;
      m_ovl   = 1'b0;
      m_win   = 0;
      m_err   = 1'b0;
      m_cnt   = 0;
      m_nbits = 0;
      hist_bits.delete();
   endtask

   // Drive one cycle of inputs, advance the model, then check the
   // registered status after the edge.
   task automatic step(input bit wr, input int pat, input int len, input bit ovl,
                       input int win, input bit st, input bit ab, input bit dv,
                       input bit din);
      bit em;
      bit ed;
      bit tail_ok;
      cfg_wr      = wr;
      cfg_pattern = pat[MAX_LEN-1:0];
      cfg_len     = len[LEN_W-1:0];
      cfg_overlap = ovl;
      cfg_window  = win[WIN_W-1:0];
      start       = st;
      abort       = ab;
      data_valid  = dv;
      data_in     = din;
      em = 1'b0;
      ed = 1'b0;
      case (m_state)
         M_IDLE: begin
            if (wr) begin
               if (len >= 1 && len <= MAX_LEN) begin
                  m_pat = pat & ((1 << MAX_LEN) - 1);
                  m_len = len;
                  m_ovl = ovl;
                  m_win = win % (1 << WIN_W);
                  m_err = 1'b0;
               end else begin
                  m_err = 1'b1;
               end
            end
            if (st) begin
               m_state = M_RUN;
               m_cnt   = 0;
               m_nbits = 0;
               hist_bits.delete();
            end
         end
         M_RUN: begin
            if (ab) begin
               m_state = M_IDLE;
            end else if (dv) begin
               hist_bits.push_back(din);
               m_nbits++;
               if (hist_bits.size() >= m_len) begin
                  tail_ok = 1'b1;
                  for (int k = 0; k < m_len; k++) begin
                     if (hist_bits[hist_bits.size() - 1 - k] != m_pat[k]) tail_ok = 1'b0;
                  end
                  if (tail_ok) begin
                     em = 1'b1;
                     if (m_cnt < CNT_MAX) m_cnt++;
                     if (!m_ovl) hist_bits.delete();
                  end
               end
               if (hist_bits.size() > MAX_LEN) void'(hist_bits.pop_front());
               if (m_win != 0 && m_nbits == m_win) begin
                  m_state = M_DONE;
                  ed = 1'b1;
               end
            end
         end
         default: m_state = M_IDLE;
      endcase
      if (em || ed) exp_q.push_back('{cyc + 1, em, ed, m_cnt});
      @(posedge clk);
      #1;
      check("busy", busy, (m_state == M_RUN));
      check("cfg_err", cfg_err, m_err);
      check("match_count", match_count, m_cnt);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cfg(input int pat, input int len, input bit ovl, input int win, input bit st);
      step(1, pat, len, ovl, win, st, 0, 0, 0);
   endtask

   task automatic go();
      step(0, 0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   // Send n bits, bits[n-1] first, optionally with random data_valid gaps.
   task automatic feed(input int bits, input int n, input bit gaps);
      for (int i = n - 1; i >= 0; i--) begin
         if (gaps) repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 0, 0, 0, 1, bits[i]);
      end
   endtask

   // Monitor: consumes one expected event whenever match or done is seen.
   initial begin : monitor
      ev_t ev;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("event_seen_at_cycle", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (!reset && (match || done)) begin
            if (exp_q.size() == 0) begin
               check("spurious_match_done", {match, done}, 0);
            end else begin
               ev = exp_q.pop_front();
               check("event_cycle", cyc, ev.cyc);
               check("match", match, ev.m);
               check("done", done, ev.d);
               check("event_count", match_count, ev.cnt);
            end
         end
      end
   end

   initial begin : stim
      int pat;
      int len;
      int win;
      bit ab;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_match", match, 0);
      check("rst_done", done, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_match_count", match_count, 0);
      reset = 1'b0;

      // 1: non-overlap 1001, window 7, config written together with start
      cfg(9, 4, 0, 7, 1);
      feed(7'b1001001, 7, 0);
      idle(3);

      // 2: same stream, overlapping
      cfg(9, 4, 1, 7, 0);
      go();
      feed(7'b1001001, 7, 0);
      idle(3);

      // 3: illegal lengths leave config alone, legal write clears the error
      cfg(5, 0, 0, 3, 0);
      cfg(5, 9, 0, 3, 0);
      go();
      feed(7'b1001001, 7, 0);
      idle(2);
      cfg(5, 3, 1, 5, 0);
      go();
      feed(5'b10101, 5, 0);
      idle(2);

      // 4: unbounded run with gaps, ignored cfg_wr/start, abort with a bit
      cfg(9, 4, 0, 0, 0);
      go();
      feed(5'b10010, 5, 1);
      step(1, 3, 2, 1, 2, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1, 1);
      idle(2);
      go();
      feed(4'b1001, 4, 1);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(1);

      // abort coincident with the final window bit: abort wins
      cfg(9, 4, 0, 3, 1);
      feed(2'b10, 2, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1, 0);
      idle(2);

      // 5: len 1 pattern 1, six ones, counter saturates
      cfg(1, 1, 1, 6, 0);
      go();
      feed(6'b111111, 6, 0);
      idle(2);

      // Randomised runs
      for (int r = 0; r < 30; r++) begin
         pat = $urandom_range(0, 255);
         len = $urandom_range(0, 9);
         win = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
         cfg(pat, len, $urandom_range(0, 1), win, $urandom_range(0, 1));
         if (m_state == M_IDLE) go();
         for (int i = 0; i <= 40 && m_state == M_RUN; i++) begin
            ab = (i == 40) || ($urandom_range(0, 29) == 0);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 255), $urandom_range(1, 8),
                 $urandom_range(0, 1), $urandom_range(0, 9), $urandom_range(0, 7) == 0,
                 ab, $urandom_range(0, 3) != 0, $urandom_range(0, 1));
         end
         idle(2);
      end

      // 6: asynchronous reset mid-run restores defaults
      cfg(5, 3, 1, 0, 0);
      step(1, 5, 0, 1, 0, 1, 0, 0, 0);
      feed(5'b10101, 5, 0);
      idle(1);
      #2;
      reset = 1'b1;
      #1;
      check("async_busy", busy, 0);
      check("async_match", match, 0);
      check("async_done", done, 0);
      check("async_cfg_err", cfg_err, 0);
      check("async_match_count", match_count, 0);
      model_reset();
      reset = 1'b0;
      go();
      feed(4'b1001, 4, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(3);

      check("pending_events", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
